// File: rtl/sys_bus_pkg.sv
// Shared definitions for the system-bus arbiter: FSM encoding and default bus geometry.
package sys_bus_pkg;

   localparam int DEF_ADDR_W  = 8;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_TIMEOUT = 15;
   localparam int TMO_W       = 8;

   // One-hot so each state decodes from a single flop.
   typedef enum logic [4:0] {
      ST_IDLE = 5'b00001,
      ST_ALE  = 5'b00010,
      ST_CMD  = 5'b00100,
      ST_XFER = 5'b01000,
      ST_CAPT = 5'b10000
   } state_t;

endpackage

// File: rtl/sys_bus_arbiter_rr_picker.sv
// Round-robin pick: the first valid requester at or after ptr, wrapping modulo N_REQ.
module rr_picker #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] pick,
   output logic [IDX_W-1:0] idx,
   output logic             any
);
   logic [IDX_W-1:0] cand [N_REQ];

   // cand[gi] is the requester index gi positions after ptr.
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
         logic [IDX_W:0] sum;
         assign sum = {1'b0, ptr} + (IDX_W+1)'(gi);
         assign cand[gi] = (sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(sum - (IDX_W+1)'(N_REQ))
                                                      : sum[IDX_W-1:0];
      end
   endgenerate

   always_comb begin
      idx  = '0;
      pick = '0;
      any  = |valid;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (valid[cand[k]]) idx = cand[k];
      end
      if (any) pick[idx] = 1'b1;
   end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter sequencing single-byte transfers over the ALE/CMD/XFER/CAPT bus handshake.
module sys_bus_arbiter
   import sys_bus_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ-1:0]        req_write,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [N_REQ*DATA_W-1:0] req_wdata,
   output logic [N_REQ-1:0]        req_grant,
   output logic [N_REQ-1:0]        req_done,
   output logic [N_REQ-1:0]        req_err,
   output logic [DATA_W-1:0]       rdata,
   input  logic                    bus_ready,
   output logic                    ale_en,
   output logic                    bus_read_en,
   output logic                    bus_write_en,
   output logic [ADDR_W-1:0]       addr_input,
   output logic [DATA_W-1:0]       data_write,
   input  logic [DATA_W-1:0]       data_read
);
   localparam int IDX_W = $clog2(N_REQ);

   state_t             state, state_next;
   logic [IDX_W-1:0]   rr_ptr, rr_ptr_next, owner, owner_next, pick_idx, rr_wrap;
   logic [N_REQ-1:0]   pick, grant_next, done_next, err_next;
   logic               pick_any, slot_write, slot_write_next, ale_next, rd_next, wr_next, tmo_hit;
   logic [DATA_W-1:0]  slot_wdata, slot_wdata_next, rdata_next, wdata_next;
   logic [ADDR_W-1:0]  addr_next;
   logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_next;
   logic [ADDR_W-1:0]  addr_arr  [N_REQ];
   logic [DATA_W-1:0]  wdata_arr [N_REQ];

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
         assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
      end
   endgenerate

   rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .pick  (pick),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT));
   assign rr_wrap = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         rr_ptr       <= '0;
         owner        <= '0;
         slot_write   <= 1'b0;
         slot_wdata   <= '0;
         tmo_cnt      <= '0;
         req_grant    <= '0;
         req_done     <= '0;
         req_err      <= '0;
         rdata        <= '0;
         ale_en       <= 1'b0;
         bus_read_en  <= 1'b0;
         bus_write_en <= 1'b0;
         addr_input   <= '0;
         data_write   <= '0;
      end else begin
         state        <= state_next;
         rr_ptr       <= rr_ptr_next;
         owner        <= owner_next;
         slot_write   <= slot_write_next;
         slot_wdata   <= slot_wdata_next;
         tmo_cnt      <= tmo_cnt_next;
         req_grant    <= grant_next;
         req_done     <= done_next;
         req_err      <= err_next;
         rdata        <= rdata_next;
         ale_en       <= ale_next;
         bus_read_en  <= rd_next;
         bus_write_en <= wr_next;
         addr_input   <= addr_next;
         data_write   <= wdata_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: if (bus_ready && pick_any) state_next = ST_ALE;
         ST_ALE:  state_next = ST_CMD;
         ST_CMD:  state_next = ST_XFER;
         ST_XFER: if (tmo_hit) state_next = ST_IDLE;
                  else if (!bus_ready) state_next = ST_CAPT;
         ST_CAPT: if (tmo_hit || bus_ready) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      rr_ptr_next     = rr_ptr;
      owner_next      = owner;
      slot_write_next = slot_write;
      slot_wdata_next = slot_wdata;
      tmo_cnt_next    = tmo_cnt;
      grant_next      = req_grant;
      done_next       = '0;
      err_next        = '0;
      rdata_next      = rdata;
      ale_next        = 1'b0;
      rd_next         = 1'b0;
      wr_next         = 1'b0;
      addr_next       = addr_input;
      wdata_next      = data_write;
      unique case (state)
         ST_IDLE: begin
            // addr_input doubles as the latched address slot for the whole transfer.
            if (bus_ready && pick_any) begin
               owner_next      = pick_idx;
               slot_write_next = req_write[pick_idx];
               slot_wdata_next = wdata_arr[pick_idx];
               addr_next       = addr_arr[pick_idx];
               grant_next      = pick;
               ale_next        = 1'b1;
            end
         end
         ST_ALE: begin
            rd_next    = ~slot_write;
            wr_next    = slot_write;
            wdata_next = slot_wdata;
         end
         ST_CMD: tmo_cnt_next = '0;
         ST_XFER, ST_CAPT: begin
            tmo_cnt_next = tmo_cnt + 1'b1;
            if (tmo_hit) begin
               err_next    = req_grant;
               grant_next  = '0;
               rr_ptr_next = rr_wrap;
            end else if (state == ST_CAPT && bus_ready) begin
               done_next   = req_grant;
               grant_next  = '0;
               rr_ptr_next = rr_wrap;
               if (!slot_write) rdata_next = data_read;
            end
         end
         default: grant_next = '0;
      endcase
   end

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Directed bench for sys_bus_arbiter with a transaction-level round-robin/memory model checked every cycle.
module tb_sys_bus_arbiter;
   localparam int N = 4, AW = 8, DW = 8, TMO = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]    req_valid = '0, req_write = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic [N-1:0]    req_grant, req_done, req_err;
   logic [DW-1:0]   rdata, data_write;
   logic [AW-1:0]   addr_input;
   logic            bus_ready = 1'b1;
   logic [DW-1:0]   data_read = '0;
   logic            ale_en, bus_read_en, bus_write_en;

   sys_bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_grant(req_grant), .req_done(req_done), .req_err(req_err),
      .rdata(rdata), .bus_ready(bus_ready), .ale_en(ale_en), .bus_read_en(bus_read_en),
      .bus_write_en(bus_write_en), .addr_input(addr_input), .data_write(data_write),
      .data_read(data_read)
   );

   // Masters, bus peripheral and reference model
   logic          m_wr [N];
   logic [7:0]    m_addr [N], m_wdata [N];
   int            post_cnt [N], served_cnt [N];
   logic [7:0]    bus_mem [256], ref_mem [256];
   int            busy_cnt = 0, busy_len = 2;
   bit            hang = 1'b0;
   bit            busy_m = 1'b0;
   int            rr_m = 0, own_m = 0, age_m = 0, last_err_age = 0, n_done_m = 0, n_err_m = 0;
   logic [7:0]    rdata_m = '0;
   logic [N-1:0]  last_drv = '0;
   int            glog [$];
   int            exp_q [$];
   int            mark = 0;
   int            n_cmp = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++)
         if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   function automatic bit pending();
      for (int i = 0; i < N; i++) if (post_cnt[i] != served_cnt[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic finish_txn();
      served_cnt[own_m]++;
      rr_m   = (own_m + 1) % N;
      busy_m = 1'b0;
   endtask

   task automatic check_cycle();
      chk("rd_wr_excl", 32'(bus_read_en & bus_write_en), 0);
      chk("ale_vs_cmd", 32'(ale_en & (bus_read_en | bus_write_en)), 0);
      chk("grant_onehot0", 32'($onehot0(req_grant)), 1);
      if (!busy_m && req_grant != '0) begin
         own_m = rr_pick(last_drv, rr_m);
         chk("grant_owner", 32'(req_grant), (own_m >= 0) ? (1 << own_m) : 0);
         if (own_m < 0) own_m = 0;
         chk("grant_ale", 32'(ale_en), 1);
         chk("grant_addr", 32'(addr_input), 32'(m_addr[own_m]));
         busy_m = 1'b1;
         age_m  = 0;
         glog.push_back(own_m);
         $display("grant  M%0d %s addr=0x%02h", own_m, m_wr[own_m] ? "WR" : "RD", m_addr[own_m]);
      end else if (busy_m) begin
         age_m++;
         if (age_m == 1) begin
            chk("cmd_ale_off", 32'(ale_en), 0);
            chk("cmd_rd", 32'(bus_read_en), 32'(!m_wr[own_m]));
            chk("cmd_wr", 32'(bus_write_en), 32'(m_wr[own_m]));
            chk("cmd_addr", 32'(addr_input), 32'(m_addr[own_m]));
            if (m_wr[own_m]) chk("cmd_wdata", 32'(data_write), 32'(m_wdata[own_m]));
         end else begin
            chk("strobes_low", 32'({ale_en, bus_read_en, bus_write_en}), 0);
         end
         if (req_done != '0) begin
            chk("done_owner", 32'(req_done), 1 << own_m);
            chk("done_no_err", 32'(req_err), 0);
            chk("done_grant_off", 32'(req_grant), 0);
            chk("done_min_lat", 32'(age_m >= 4), 1);
            if (m_wr[own_m]) ref_mem[m_addr[own_m]] = m_wdata[own_m];
            else rdata_m = ref_mem[m_addr[own_m]];
            n_done_m++;
            $display("done   M%0d age=%0d rdata=0x%02h", own_m, age_m, rdata);
            finish_txn();
         end else if (req_err != '0) begin
            chk("err_owner", 32'(req_err), 1 << own_m);
            chk("err_age", 32'(age_m), TMO + 3);
            last_err_age = age_m;
            n_err_m++;
            $display("error  M%0d age=%0d", own_m, age_m);
            finish_txn();
         end else begin
            chk("grant_held", 32'(req_grant), 1 << own_m);
            if (age_m > TMO + 3) begin
               chk("txn_stuck", 32'(age_m), TMO + 3);
               busy_m = 1'b0;
            end
         end
      end else begin
         chk("idle_quiet", 32'({req_done, req_err, ale_en, bus_read_en, bus_write_en}), 0);
      end
      chk("rdata", 32'(rdata), 32'(rdata_m));
   endtask

   task automatic bus_step();
      if (rst) begin
         bus_ready = 1'b1;
         busy_cnt  = 0;
      end else if (bus_read_en || bus_write_en) begin
         if (bus_write_en) bus_mem[addr_input] = data_write;
         else data_read = bus_mem[addr_input];
         bus_ready = 1'b0;
         busy_cnt  = hang ? -1 : busy_len;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) bus_ready = 1'b1;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (rst) begin
         busy_m  = 1'b0;
         rr_m    = 0;
         rdata_m = '0;
      end else begin
         check_cycle();
      end
      bus_step();
      for (int i = 0; i < N; i++) begin
         req_valid[i]            = (post_cnt[i] != served_cnt[i]);
         req_write[i]            = m_wr[i];
         req_addr[i*AW +: AW]    = m_addr[i];
         req_wdata[i*DW +: DW]   = m_wdata[i];
      end
      last_drv = req_valid;
   endtask

   task automatic post(input int m, input logic wr, input logic [7:0] a, input logic [7:0] d);
      m_wr[m]    = wr;
      m_addr[m]  = a;
      m_wdata[m] = d;
      post_cnt[m]++;
   endtask

   task automatic wait_all(input int budget);
      int n = 0;
      while (pending() && n < budget) begin
         tick();
         n++;
      end
      chk("wait_budget", 32'(pending()), 0);
   endtask

   task automatic check_order(input string nm);
      chk({nm, "_count"}, 32'(glog.size() - mark), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++)
         if (mark + k < glog.size()) chk({nm, "_order"}, 32'(glog[mark + k]), 32'(exp_q[k]));
      mark = glog.size();
   endtask

   initial begin
      int n, d0, e0;
      for (int a = 0; a < 256; a++) begin
         bus_mem[a] = 8'(a * 13 + 1);
         ref_mem[a] = 8'(a * 13 + 1);
      end
      bus_mem[8'h10] = 8'hA5;
      ref_mem[8'h10] = 8'hA5;
      for (int i = 0; i < N; i++) begin
         m_wr[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0; post_cnt[i] = 0; served_cnt[i] = 0;
      end

      repeat (3) tick();
      chk("rst_grant", 32'(req_grant), 0);
      chk("rst_done_err", 32'({req_done, req_err}), 0);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_strobes", 32'({ale_en, bus_read_en, bus_write_en}), 0);
      chk("rst_addr_data", 32'({addr_input, data_write}), 0);
      rst = 1'b0;
      tick();

      // Single read
      post(0, 1'b0, 8'h10, 8'h00);
      wait_all(100);
      chk("t1_rdata", 32'(rdata), 32'h A5);
      exp_q = '{0};
      check_order("t1");

      // Write then readback, slower bus
      busy_len = 4;
      post(2, 1'b1, 8'h80, 8'h3C);
      wait_all(100);
      chk("t2_busmem", 32'(bus_mem[8'h80]), 32'h3C);
      post(2, 1'b0, 8'h80, 8'h00);
      wait_all(100);
      chk("t2_rdata", 32'(rdata), 32'h3C);
      busy_len = 2;
      post(3, 1'b0, 8'h11, 8'h00);
      wait_all(100);
      mark = glog.size();

      // Contention from rr_ptr=0, then M0 re-requests
      for (int i = 0; i < N; i++) post(i, 1'b0, 8'(8'h20 + i), 8'h00);
      n = 0;
      while (served_cnt[0] != post_cnt[0] && n < 100) begin
         tick();
         n++;
      end
      post(0, 1'b0, 8'h30, 8'h00);
      wait_all(300);
      chk("t3_rdata", 32'(rdata), 32'h71);
      exp_q = '{0, 1, 2, 3, 0};
      check_order("t3");

      // Wrap: bring rr_ptr to 3, then M1+M3
      post(2, 1'b0, 8'h40, 8'h00);
      wait_all(100);
      mark = glog.size();
      post(1, 1'b0, 8'h41, 8'h00);
      post(3, 1'b0, 8'h43, 8'h00);
      wait_all(200);
      exp_q = '{3, 1};
      check_order("t4");
      for (int i = 0; i < N; i++) post(i, 1'b1, 8'(8'h90 + i), 8'(8'hC0 + i));
      wait_all(300);
      exp_q = '{2, 3, 0, 1};
      check_order("t4_all");
      chk("t4_busmem", 32'(bus_mem[8'h93]), 32'hC3);

      // Reset during CMD
      post(1, 1'b0, 8'h50, 8'h00);
      post(3, 1'b0, 8'h51, 8'h00);
      n = 0;
      while (!(bus_read_en || bus_write_en) && n < 20) begin
         tick();
         n++;
      end
      chk("t5_cmd_owner", 32'(req_grant), 32'h8);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_strobes", 32'({ale_en, bus_read_en, bus_write_en}), 0);
      chk("t5_rst_grant", 32'(req_grant), 0);
      tick();
      tick();
      rst = 1'b0;
      mark = glog.size();
      wait_all(200);
      exp_q = '{1, 3};
      check_order("t5");
      chk("t5_rdata", 32'(rdata), 32'h1E);

      // Timeout: bus never returns ready
      hang = 1'b1;
      d0 = n_done_m;
      e0 = n_err_m;
      post(2, 1'b0, 8'h60, 8'h00);
      wait_all(100);
      chk("t6_err_age", 32'(last_err_age), 18);
      chk("t6_err_count", 32'(n_err_m - e0), 1);
      chk("t6_no_done", 32'(n_done_m - d0), 0);
      chk("t6_rdata_held", 32'(rdata), 32'h1E);
      exp_q = '{2};
      check_order("t6");
      hang = 1'b0;
      bus_ready = 1'b1;
      busy_cnt = 0;
      tick();

      // Recovery after timeout
      post(0, 1'b0, 8'h10, 8'h00);
      wait_all(100);
      chk("t7_rdata", 32'(rdata), 32'hA5);
      exp_q = '{0};
      check_order("t7");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
